// File: rtl/dma_pkg.sv
// Shared definitions for the DMA active-cycle sequencer.
// Contents: channel count, state encoding, transfer-type encoding, one-hot helper.
package dma_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    // Sequencer states: idle, hold-request, then the four transfer states.
    typedef logic [2:0] dma_state_e;
    localparam dma_state_e ST_SI = 3'd0;
    localparam dma_state_e ST_S0 = 3'd1;
    localparam dma_state_e ST_S1 = 3'd2;
    localparam dma_state_e ST_S2 = 3'd3;
    localparam dma_state_e ST_S3 = 3'd4;
    localparam dma_state_e ST_S4 = 3'd5;

    // Per-channel transfer type from the mode register; 11 behaves as verify.
    typedef logic [1:0] xfer_type_e;
    localparam xfer_type_e XFER_VERIFY = 2'b00;
    localparam xfer_type_e XFER_WRITE  = 2'b01;
    localparam xfer_type_e XFER_READ   = 2'b10;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v     = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dma_priority_arb.sv
// Request arbiter for the DMA sequencer.
// Ports: clk/rst_n, req (valid requests), rotate (select rotating priority),
//        upd/upd_ch (retire a serviced channel to lowest priority),
//        grant (winning channel), valid (any request present).
// With ROTATING_PRIORITY_EN undefined, priority is fixed (ch0 highest) and
// the pointer register does not exist.
module dma_priority_arb
    import dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              rotate,
    input  logic              upd,
    input  logic [CH_W-1:0]   upd_ch,
    output logic [CH_W-1:0]   grant,
    output logic              valid
);

    // Lowest-priority channel; the search starts just above it.
    logic [CH_W-1:0] base;
    logic [CH_W-1:0] cand;

`ifdef ROTATING_PRIORITY_EN
    logic [CH_W-1:0] ptr;

    // Pointer holds the most recently retired channel; reset makes ch0 highest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= CH_W'(NUM_CH - 1);
        end else if (upd) begin
            ptr <= upd_ch;
        end
    end

    assign base = rotate ? ptr : CH_W'(NUM_CH - 1);
`else
    logic unused_cfg;
    assign unused_cfg = ^{clk, rst_n, rotate, upd, upd_ch};
    assign base       = CH_W'(NUM_CH - 1);
`endif

    // Scan from lowest to highest priority so the highest-priority hit wins last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = int'(NUM_CH); k >= 1; k--) begin
            cand = base + CH_W'(k);
            if (req[cand]) begin
                grant = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_timing_ctrl.sv
// Active-cycle sequencer for an 8237A-style DMA controller.
// Inputs : CLK, RESET_N, DREQ, HLDA, EOP_N, mask, mode_type, mode_block,
//          cmd_disable, cmd_rotate, tc_in.
// Outputs: HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N (registered),
//          svc_ch, upd_strb (registered), EOP_OUT_N, tc_pulse (decoded from the
//          registered S4 state and the live tc_in/EOP_N so they land in that S4).
// Build option: ROTATING_PRIORITY_EN enables cmd_rotate and the rotation pointer.
module dma_timing_ctrl
    import dma_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [NUM_CH-1:0]   DREQ,
    input  logic                HLDA,
    input  logic                EOP_N,
    input  logic [NUM_CH-1:0]   mask,
    input  logic [2*NUM_CH-1:0] mode_type,
    input  logic [NUM_CH-1:0]   mode_block,
    input  logic                cmd_disable,
    input  logic                cmd_rotate,
    input  logic                tc_in,
    output logic                HRQ,
    output logic [NUM_CH-1:0]   DACK,
    output logic                AEN,
    output logic                ADSTB,
    output logic                MEMR_N,
    output logic                MEMW_N,
    output logic                IOR_N,
    output logic                IOW_N,
    output logic                EOP_OUT_N,
    output logic [CH_W-1:0]     svc_ch,
    output logic                upd_strb,
    output logic [NUM_CH-1:0]   tc_pulse
);

    dma_state_e        state, state_n;
    logic [CH_W-1:0]   svc_n;
    logic              eop_seen, eop_seen_n;
    logic [NUM_CH-1:0] req_valid;
    logic [CH_W-1:0]   grant;
    logic              grant_valid;
    logic              ptr_upd;
    logic              term_c;
    logic              act_n;
    logic              rd_ph_n;
    xfer_type_e        xtype_n;

    assign req_valid = cmd_disable ? '0 : (DREQ & ~mask);

    dma_priority_arb u_arb (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .req    (req_valid),
        .rotate (cmd_rotate),
        .upd    (ptr_upd),
        .upd_ch (svc_ch),
        .grant  (grant),
        .valid  (grant_valid)
    );

    // Termination is decided in S4; an EOP seen earlier in S2/S3 is remembered.
    assign term_c    = (state == ST_S4) && (tc_in || !EOP_N || eop_seen);
    assign EOP_OUT_N = !term_c;
    assign tc_pulse  = term_c ? ch_onehot(svc_ch) : '0;

    // Next state, latched channel, and next-cycle output decode.
    always_comb begin
        state_n    = state;
        svc_n      = svc_ch;
        eop_seen_n = eop_seen;
        ptr_upd    = 1'b0;

        case (state)
            ST_SI: begin
                if (grant_valid) begin
                    svc_n   = grant;
                    state_n = ST_S0;
                end
            end
            ST_S0: begin
                if (HLDA) begin
                    state_n = ST_S1;
                end else if (!req_valid[svc_ch]) begin
                    state_n = ST_SI;
                end
            end
            ST_S1: state_n = ST_S2;
            ST_S2: state_n = ST_S3;
            ST_S3: state_n = ST_S4;
            ST_S4: begin
                if (!mode_block[svc_ch] || term_c || !DREQ[svc_ch]) begin
                    state_n = ST_SI;
                    ptr_upd = 1'b1;
                end else begin
                    state_n = ST_S1;
                end
            end
            default: state_n = ST_SI;
        endcase

        // Losing the bus mid-transfer abandons it with no pointer step.
        if ((state == ST_S1 || state == ST_S2 || state == ST_S3 || state == ST_S4) && !HLDA) begin
            state_n = ST_SI;
            svc_n   = '0;
            ptr_upd = 1'b0;
        end

        if ((state == ST_S2 || state == ST_S3) && !EOP_N) begin
            eop_seen_n = 1'b1;
        end
        if (state_n == ST_S1 || state_n == ST_SI) begin
            eop_seen_n = 1'b0;
        end

        act_n   = (state_n == ST_S1) || (state_n == ST_S2) ||
                  (state_n == ST_S3) || (state_n == ST_S4);
        rd_ph_n = (state_n == ST_S2) || (state_n == ST_S3);
        xtype_n = mode_type[{svc_n, 1'b0} +: 2];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_SI;
            svc_ch   <= '0;
            eop_seen <= 1'b0;
            HRQ      <= 1'b0;
            DACK     <= '0;
            AEN      <= 1'b0;
            ADSTB    <= 1'b0;
            MEMR_N   <= 1'b1;
            MEMW_N   <= 1'b1;
            IOR_N    <= 1'b1;
            IOW_N    <= 1'b1;
            upd_strb <= 1'b0;
        end else begin
            state    <= state_n;
            svc_ch   <= svc_n;
            eop_seen <= eop_seen_n;
            HRQ      <= (state_n != ST_SI);
            DACK     <= act_n ? ch_onehot(svc_n) : '0;
            AEN      <= act_n;
            ADSTB    <= (state_n == ST_S1);
            MEMR_N   <= !(rd_ph_n && xtype_n == XFER_READ);
            IOR_N    <= !(rd_ph_n && xtype_n == XFER_WRITE);
            IOW_N    <= !((state_n == ST_S3) && xtype_n == XFER_READ);
            MEMW_N   <= !((state_n == ST_S3) && xtype_n == XFER_WRITE);
            upd_strb <= (state_n == ST_S4);
        end
    end

endmodule
